// File: rtl/stopwatch_core.sv
// stopwatch_core: conditions the user inputs, divides clk down to a 1 Hz tick
// and runs the IDLE/RUN/PAUSE/ADJUST control for a 0..MAX_COUNT seconds count.
module stopwatch_core #(
    parameter int unsigned CLK_HZ          = 100000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_COUNT       = 5999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_inc,
    input  logic        adj_mode,
    input  logic        adj_sel,
    output logic [12:0] count,
    output logic        running,
    output logic        tick,
    output logic        wrap
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0]   COUNT_MAX  = 13'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        ADJUST = 2'd3
    } state_t;

    // input bit order: 0 start, 1 clear, 2 inc, 3 adj_mode, 4 adj_sel
    logic [4:0]    w_raw;
    logic [4:0]    r_sync1;
    logic [4:0]    r_sync2;
    logic [1:0]    r_settle;
    logic [3:0]    r_acc;
    logic [DW-1:0] r_db_cnt [4];
    logic [2:0]    r_acc_d;
    logic [2:0]    r_armed;
    logic [2:0]    r_press;

    logic          w_start;
    logic          w_clear;
    logic          w_inc;
    logic          w_adj_lvl;
    logic          w_adj_sel;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [12:0]   r_count;
    logic [12:0]   w_count_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_running;
    logic          w_tick;
    logic          w_wrap;

    logic [12:0]   w_min;
    logic [12:0]   w_sec;
    logic [12:0]   w_min_inc;
    logic [12:0]   w_sec_inc;
    logic [12:0]   w_adj_val;
    logic [12:0]   w_adj_count;

    assign w_raw = {adj_sel, adj_mode, btn_inc, btn_clear, btn_start};

    // two-flop synchronisers plus a settle flag marking when the chain holds live samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_settle <= '0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_settle <= {r_settle[0], 1'b1};
        end
    end

    // debounce: accepted level flips after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_acc[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_acc[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // press pulses on accepted rising edges; a button only arms once it has been
    // seen released after reset, so a button held through reset cannot fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_d <= '0;
            r_armed <= '0;
            r_press <= '0;
        end else begin
            r_acc_d <= r_acc[2:0];
            r_armed <= r_armed | ({3{r_settle[1]}} & ~r_sync2[2:0] & ~r_acc[2:0]);
            r_press <= r_armed & r_acc[2:0] & ~r_acc_d;
        end
    end

    assign w_start   = r_press[0];
    assign w_clear   = r_press[1];
    assign w_inc     = r_press[2];
    assign w_adj_lvl = r_acc[3];
    assign w_adj_sel = r_sync2[4];

    assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST) && !w_clear;
    assign w_wrap = w_tick && (r_count >= COUNT_MAX);

    // MM:SS field adjust: split count, bump one field modulo its range, recombine
    always_comb begin
        w_min       = r_count / 13'd60;
        w_sec       = r_count % 13'd60;
        w_sec_inc   = (w_sec >= 13'd59) ? '0 : w_sec + 13'd1;
        w_min_inc   = (w_min >= 13'd99) ? '0 : w_min + 13'd1;
        w_adj_val   = w_adj_sel ? (w_min_inc * 13'd60 + w_sec)
                                : (w_min * 13'd60 + w_sec_inc);
        w_adj_count = (w_adj_val > COUNT_MAX) ? '0 : w_adj_val;
    end

    // next-state, count and prescaler decode; clear overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        if (w_clear) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        w_state_nxt = RUN;
                        w_presc_nxt = '0;
                    end else if (w_adj_lvl) begin
                        w_state_nxt = ADJUST;
                    end
                end
                RUN: begin
                    if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = '0;
                        w_count_nxt = (r_count >= COUNT_MAX) ? '0 : r_count + 13'd1;
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                    if (w_start) begin
                        w_state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (w_start) begin
                        w_state_nxt = RUN;
                    end else if (w_adj_lvl) begin
                        w_state_nxt = ADJUST;
                    end
                end
                ADJUST: begin
                    if (w_inc) begin
                        w_count_nxt = w_adj_count;
                    end
                    if (!w_adj_lvl) begin
                        w_state_nxt = PAUSE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // state, count, prescaler and running registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_presc   <= '0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign tick    = w_tick;
    assign wrap    = w_wrap;

endmodule
